sim_memory_arbiter: RTL and testbench
=====================================

Name: sim_memory_arbiter

Overview:
- Two-requester arbiter that shares one simulation memory model port between the instruction-fetch path (port 0, read-only) and the load/store path (port 1, read/write).
- Grants one request per cycle using round-robin.
- Records the owner of every read in an in-order tag FIFO, because the memory returns read data strictly in request order.
- Routes each returned 64-bit line, and the matching response backpressure, to the requester that owns it.
- Sits between the core's memory ports and the memory model in the simulation top level.

Parameters:
- P_TAG_DEPTH, 16, maximum outstanding reads tracked (power of two).
- P_TAG_DEPTH_N, 4, log2(P_TAG_DEPTH).

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  reset; one clock, synchronous, active-low.
- iINST_REQ  in  1  instruction read request.
- oINST_LOCK  out  1  request not accepted this cycle; requester holds request.
- iINST_ADDR  in  32  byte address (issued as word order, mask 4'b1111).
- oINST_VALID  out  1  read data valid to port 0.
- iINST_LOCK  in  1  port 0 cannot take response.
- oINST_DATA  out  64  read line.
- iDATA_REQ  in  1  data request.
- oDATA_LOCK  out  1  as oINST_LOCK.
- iDATA_ORDER  in  2  00 byte, 01 half, 10 word, 11 none.
- iDATA_MASK  in  4  byte enables.
- iDATA_RW  in  1  1 write, 0 read.
- iDATA_ADDR  in  32  byte address.
- iDATA_DATA  in  32  write data.
- oDATA_VALID  out  1  read data valid to port 1.
- iDATA_LOCK  in  1  port 1 cannot take response.
- oDATA_DATA  out  64  read line.
- oMEM_REQ, oMEM_ORDER[2], oMEM_MASK[4], oMEM_RW, oMEM_ADDR[32], oMEM_DATA[32]  out  memory request bus.
- iMEM_LOCK  in  1  memory cannot accept a request.
- iMEM_VALID  in  1  memory response valid.
- oMEM_LOCK  out  1  response backpressure to memory.
- iMEM_DATA  in  64  memory response data.
- oOUTSTANDING  out  P_TAG_DEPTH_N+1  reads in flight.

Behaviour:
- Registered state:
  - b_last_grant (1 bit).
  - Tag FIFO (1-bit owner entries, 0=inst, 1=data) and its count.
- Reset (inRESET low at a clock edge): b_last_grant=1, so port 0 wins the first tie. Tag FIFO is emptied and oOUTSTANDING=0. Reset is honoured mid-transfer; in-flight tags are discarded, and the bench resets the memory model together with this block.
- Eligibility:
  - Port 0 is eligible when iINST_REQ=1 and the tag FIFO is not full.
  - Port 1 is eligible when iDATA_REQ=1 and (iDATA_RW=1 or the tag FIFO is not full). Writes never consume a tag.
  - Full is judged on the registered count. A push is blocked at count==P_TAG_DEPTH even if a pop occurs the same cycle.
- Grant (combinational):
  - If only one port is eligible, it wins.
  - If both are eligible, the port other than b_last_grant wins.
  - Nothing is granted while iMEM_LOCK=1.
- Acceptance and issue:
  - Accept = grant & !iMEM_LOCK.
  - oMEM_REQ = accept. oMEM_* fields mux from the winner; port 0 drives RW=0, ORDER=10, MASK=1111, DATA=0.
  - oX_LOCK = iX_REQ & !acceptX. With no request, LOCK=0.
- Tag and grant update:
  - On an accepted read, push the owner id.
  - On any accept, b_last_grant <= winner.
- Response path:
  - oMEM_LOCK = (tag empty) ? 0 : (head==0 ? iINST_LOCK : iDATA_LOCK).
  - On iMEM_VALID=1: assert VALID only to the head owner, with oX_DATA=iMEM_DATA, then pop the head. The other port's VALID stays 0.
  - Both X_DATA outputs carry iMEM_DATA unconditionally; VALID qualifies them.
- Simultaneous push and pop in one cycle: count unchanged, FIFO contents shift correctly.
- Error checks (simulation only; $display "[ERROR][sim_memory_arbiter.v]"):
  - iMEM_VALID while the tag FIFO is empty.
  - Pointer wrap-around must not corrupt ordering.
- Latency: request to memory is 0 cycles (combinational); response routing is 0 cycles.

Decomposition:
- Shared package sim_memory_pkg: ORDER_BYTE/HALF/WORD/NONE constants, PORT_INST=0 / PORT_DATA=1, default tag depth.
- One sub-module: sim_memory_arbiter_tag_fifo, a 1-bit-wide synchronous FIFO with registered count, full/empty and simultaneous push/pop.

Test Plan:
- Reset, then iINST_REQ and iDATA_REQ (read) both high for 4 cycles -> grants alternate inst,data,inst,data. Responses arrive with oINST_VALID, oDATA_VALID alternating, and data matches memory at the respective addresses.
- Data write to 0x100 (mask 0011, data 0x0000ABCD) while inst reads 0x0 -> write issued with RW=1 and no tag pushed (oOUTSTANDING counts inst reads only). A later data read of 0x100 returns the low half 0xABCD.
- Hold iMEM_LOCK=1 for 3 cycles with both requests -> oMEM_REQ=0 and both oX_LOCK=1. After release, port 0 is granted first.
- Issue 16 inst reads with iINST_LOCK=1 -> oOUTSTANDING=16, 17th request LOCKed, oMEM_LOCK=1. Drop iINST_LOCK -> 16 ordered responses, count returns to 0.
- Head owner is data and iDATA_LOCK=1 while iINST_LOCK=0 -> oMEM_LOCK=1 and no VALID to either port, preserving order.
- Assert inRESET low with 5 reads outstanding -> next cycle oOUTSTANDING=0, all VALID=0, b_last_grant=1.

Source files
------------

// File: rtl/sim_memory_pkg.sv
// Shared constants and command types for the simulation memory port and its arbiter.
// Owner ids double as the tag values recorded for every outstanding read.
package sim_memory_pkg;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_NONE = 2'b11;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam int TAG_DEPTH_DEFAULT   = 16;
    localparam int TAG_DEPTH_N_DEFAULT = 4;

    typedef struct packed {
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_cmd_t;

    // Instruction fetches are always full-word reads.
    function automatic mem_cmd_t inst_fetch_cmd(input logic [31:0] addr);
        mem_cmd_t cmd;
        cmd.order = ORDER_WORD;
        cmd.mask  = 4'b1111;
        cmd.rw    = 1'b0;
        cmd.addr  = addr;
        cmd.data  = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/sim_memory_arbiter_tag_fifo.sv
// In-order owner FIFO for outstanding reads: 1-bit entries, registered count,
// simultaneous push and pop leave the count unchanged.
module sim_memory_arbiter_tag_fifo
    import sim_memory_pkg::*;
#(
    parameter int DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               push_data,
    input  logic               pop,
    output logic               head,
    output logic [DEPTH_N:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [DEPTH_N:0] DEPTH_CNT = (DEPTH_N + 1)'(DEPTH);

    logic [DEPTH-1:0]   slots;
    logic [DEPTH_N-1:0] wr_ptr;
    logic [DEPTH_N-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pointers wrap freely; the distance between them must always equal the count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count[DEPTH_N-1:0] == DEPTH_N'(wr_ptr - rd_ptr) && count <= DEPTH_CNT)
            else $error("[ERROR][sim_memory_arbiter.v] tag fifo pointer wrap corrupted ordering");
            assert (!(push && full))
            else $error("[ERROR][sim_memory_arbiter.v] tag push while fifo full");
        end
    end

endmodule

// File: rtl/sim_memory_arbiter.sv
// Round-robin arbiter sharing one simulation memory port between instruction fetch
// (port 0, read-only) and load/store (port 1); read responses return in request order.
module sim_memory_arbiter
    import sim_memory_pkg::*;
#(
    parameter int P_TAG_DEPTH   = TAG_DEPTH_DEFAULT,
    parameter int P_TAG_DEPTH_N = TAG_DEPTH_N_DEFAULT
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iINST_REQ,
    output logic                   oINST_LOCK,
    input  logic [31:0]            iINST_ADDR,
    output logic                   oINST_VALID,
    input  logic                   iINST_LOCK,
    output logic [63:0]            oINST_DATA,
    input  logic                   iDATA_REQ,
    output logic                   oDATA_LOCK,
    input  logic [1:0]             iDATA_ORDER,
    input  logic [3:0]             iDATA_MASK,
    input  logic                   iDATA_RW,
    input  logic [31:0]            iDATA_ADDR,
    input  logic [31:0]            iDATA_DATA,
    output logic                   oDATA_VALID,
    input  logic                   iDATA_LOCK,
    output logic [63:0]            oDATA_DATA,
    output logic                   oMEM_REQ,
    output logic [1:0]             oMEM_ORDER,
    output logic [3:0]             oMEM_MASK,
    output logic                   oMEM_RW,
    output logic [31:0]            oMEM_ADDR,
    output logic [31:0]            oMEM_DATA,
    input  logic                   iMEM_LOCK,
    input  logic                   iMEM_VALID,
    output logic                   oMEM_LOCK,
    input  logic [63:0]            iMEM_DATA,
    output logic [P_TAG_DEPTH_N:0] oOUTSTANDING
);

    // Handshake: a request transfers in the cycle REQ=1 and LOCK=0; while LOCK=1 the
    // requester holds its request unchanged. Responses transfer when VALID=1 from the
    // producer and the consumer's LOCK=0; a locked response is held by the producer.

    logic                   b_last_grant;
    logic                   tag_full;
    logic                   tag_empty;
    logic                   tag_head;
    logic [P_TAG_DEPTH_N:0] tag_count;
    logic                   elig_inst;
    logic                   elig_data;
    logic                   grant_any;
    logic                   winner;
    logic                   accept_inst;
    logic                   accept_data;
    logic                   tag_push;
    logic                   head_lock;
    logic                   resp_fire;
    mem_cmd_t               inst_cmd;
    mem_cmd_t               data_cmd;
    mem_cmd_t               mem_cmd;

    // Writes never wait for a tag, so a full FIFO only stalls reads.
    assign elig_inst = iINST_REQ & ~tag_full;
    assign elig_data = iDATA_REQ & (iDATA_RW | ~tag_full);

    always_comb begin
        grant_any = 1'b0;
        winner    = PORT_INST;
        if (!iMEM_LOCK) begin
            if (elig_inst && elig_data) begin
                grant_any = 1'b1;
                winner    = ~b_last_grant;
            end else if (elig_inst) begin
                grant_any = 1'b1;
                winner    = PORT_INST;
            end else if (elig_data) begin
                grant_any = 1'b1;
                winner    = PORT_DATA;
            end
        end
    end

    assign accept_inst = grant_any & (winner == PORT_INST);
    assign accept_data = grant_any & (winner == PORT_DATA);

    assign inst_cmd = inst_fetch_cmd(iINST_ADDR);
    assign data_cmd = '{order: iDATA_ORDER, mask: iDATA_MASK, rw: iDATA_RW,
                        addr: iDATA_ADDR, data: iDATA_DATA};
    assign mem_cmd  = (winner == PORT_DATA) ? data_cmd : inst_cmd;

    assign oMEM_REQ   = grant_any;
    assign oMEM_ORDER = mem_cmd.order;
    assign oMEM_MASK  = mem_cmd.mask;
    assign oMEM_RW    = mem_cmd.rw;
    assign oMEM_ADDR  = mem_cmd.addr;
    assign oMEM_DATA  = mem_cmd.data;

    assign oINST_LOCK = iINST_REQ & ~accept_inst;
    assign oDATA_LOCK = iDATA_REQ & ~accept_data;

    // Only reads produce a response and therefore a tag; the winner id is the owner.
    assign tag_push = accept_inst | (accept_data & ~iDATA_RW);

    // Backpressure follows whoever owns the oldest read, so order is never broken.
    assign head_lock = tag_empty ? 1'b0 : ((tag_head == PORT_INST) ? iINST_LOCK : iDATA_LOCK);
    assign resp_fire = iMEM_VALID & ~tag_empty & ~head_lock;

    assign oMEM_LOCK    = head_lock;
    assign oINST_VALID  = resp_fire & (tag_head == PORT_INST);
    assign oDATA_VALID  = resp_fire & (tag_head == PORT_DATA);
    assign oINST_DATA   = iMEM_DATA;
    assign oDATA_DATA   = iMEM_DATA;
    assign oOUTSTANDING = tag_count;

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            b_last_grant <= PORT_DATA;
        end else if (grant_any) begin
            b_last_grant <= winner;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (inRESET) begin
            assert (!(iMEM_VALID && tag_empty))
            else $error("[ERROR][sim_memory_arbiter.v] memory response with no read outstanding");
        end
    end

    sim_memory_arbiter_tag_fifo #(
        .DEPTH   (P_TAG_DEPTH),
        .DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .clk       (iCLOCK),
        .rst_n     (inRESET),
        .push      (tag_push),
        .push_data (winner),
        .pop       (resp_fire),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_sim_memory_arbiter.sv
// Directed table-driven bench for sim_memory_arbiter with a small in-order memory model.
// Each vector is applied just after a rising edge and checked on the falling edge.
module tb_sim_memory_arbiter;
    import sim_memory_pkg::*;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iINST_REQ, oINST_LOCK, oINST_VALID, iINST_LOCK;
    logic [31:0] iINST_ADDR;
    logic [63:0] oINST_DATA;
    logic        iDATA_REQ, oDATA_LOCK, iDATA_RW, oDATA_VALID, iDATA_LOCK;
    logic [1:0]  iDATA_ORDER;
    logic [3:0]  iDATA_MASK;
    logic [31:0] iDATA_ADDR, iDATA_DATA;
    logic [63:0] oDATA_DATA;
    logic        oMEM_REQ, oMEM_RW, iMEM_LOCK, iMEM_VALID, oMEM_LOCK;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic [31:0] oMEM_ADDR, oMEM_DATA;
    logic [63:0] iMEM_DATA;
    logic [4:0]  oOUTSTANDING;

    sim_memory_arbiter #(.P_TAG_DEPTH(16), .P_TAG_DEPTH_N(4)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iINST_REQ(iINST_REQ), .oINST_LOCK(oINST_LOCK), .iINST_ADDR(iINST_ADDR),
        .oINST_VALID(oINST_VALID), .iINST_LOCK(iINST_LOCK), .oINST_DATA(oINST_DATA),
        .iDATA_REQ(iDATA_REQ), .oDATA_LOCK(oDATA_LOCK), .iDATA_ORDER(iDATA_ORDER),
        .iDATA_MASK(iDATA_MASK), .iDATA_RW(iDATA_RW), .iDATA_ADDR(iDATA_ADDR),
        .iDATA_DATA(iDATA_DATA), .oDATA_VALID(oDATA_VALID), .iDATA_LOCK(iDATA_LOCK),
        .oDATA_DATA(oDATA_DATA),
        .oMEM_REQ(oMEM_REQ), .oMEM_ORDER(oMEM_ORDER), .oMEM_MASK(oMEM_MASK),
        .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
        .iMEM_LOCK(iMEM_LOCK), .iMEM_VALID(iMEM_VALID), .oMEM_LOCK(oMEM_LOCK),
        .iMEM_DATA(iMEM_DATA), .oOUTSTANDING(oOUTSTANDING)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic        rst_n;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        drw;
        logic [1:0]  dorder;
        logic [3:0]  dmask;
        logic [31:0] daddr;
        logic [31:0] ddata;
        logic        mlock;
        logic        ilock;
        logic        dlock;
        logic        mvalid;
        logic        e_mreq;
        logic        e_win;
        logic        e_ilk;
        logic        e_dlk;
        logic        e_ivld;
        logic        e_dvld;
        logic        e_mlk;
        logic [4:0]  e_out;
        logic [31:0] e_raddr;
        logic        e_abcd;
    } vec_t;

    vec_t cur;
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    // ---------------- memory model ----------------
    logic [31:0] pend_q[$];
    logic [63:0] mem[int unsigned];

    function automatic logic [63:0] init_line(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:3], 3'b000};
        return {~al, al ^ 32'h5A5A_0000};
    endfunction

    function automatic logic [63:0] mem_line(input logic [31:0] a);
        if (mem.exists(int'(a[31:3]))) return mem[int'(a[31:3])];
        return init_line(a);
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [63:0] line;
        line = mem_line(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) line[(a[2] ? 32 : 0) + b*8 +: 8] = d[b*8 +: 8];
        end
        mem[int'(a[31:3])] = line;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int step, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // ---------------- vector builders ----------------
    task automatic clr();
        cur = '{default: '0};
        cur.rst_n = 1'b1;
    endtask

    task automatic ri(input logic [31:0] a);
        cur.ireq  = 1'b1;
        cur.iaddr = a;
    endtask

    task automatic rd(input logic rw, input logic [31:0] a);
        cur.dreq   = 1'b1;
        cur.drw    = rw;
        cur.daddr  = a;
        cur.dorder = ORDER_WORD;
        cur.dmask  = 4'hf;
        cur.ddata  = rw ? 32'h1234_5678 : 32'h0;
    endtask

    task automatic wr_abcd();
        cur.dreq   = 1'b1;
        cur.drw    = 1'b1;
        cur.daddr  = 32'h100;
        cur.dorder = ORDER_HALF;
        cur.dmask  = 4'b0011;
        cur.ddata  = 32'h0000_ABCD;
    endtask

    task automatic resp(input logic to_data, input logic [31:0] a);
        cur.mvalid  = 1'b1;
        cur.e_ivld  = ~to_data;
        cur.e_dvld  = to_data;
        cur.e_raddr = a;
    endtask

    task automatic ex(input logic mreq, input logic win, input logic ilk, input logic dlk,
                      input logic mlk, input int out);
        cur.e_mreq = mreq;
        cur.e_win  = win;
        cur.e_ilk  = ilk;
        cur.e_dlk  = dlk;
        cur.e_mlk  = mlk;
        cur.e_out  = 5'(out);
        vecs.push_back(cur);
    endtask

    // ---------------- driver ----------------
    task automatic run_step(input vec_t v, input int idx);
        logic [63:0] exp_line;
        @(posedge iCLOCK);
        #1;
        inRESET     = v.rst_n;
        iINST_REQ   = v.ireq;
        iINST_ADDR  = v.iaddr;
        iINST_LOCK  = v.ilock;
        iDATA_REQ   = v.dreq;
        iDATA_RW    = v.drw;
        iDATA_ORDER = v.dorder;
        iDATA_MASK  = v.dmask;
        iDATA_ADDR  = v.daddr;
        iDATA_DATA  = v.ddata;
        iDATA_LOCK  = v.dlock;
        iMEM_LOCK   = v.mlock;
        iMEM_VALID  = v.mvalid;
        iMEM_DATA   = (v.mvalid && pend_q.size() > 0) ? mem_line(pend_q[0]) : 64'h0;
        @(negedge iCLOCK);
        chk("mem_req", idx, 64'(oMEM_REQ), 64'(v.e_mreq));
        chk("inst_lock", idx, 64'(oINST_LOCK), 64'(v.e_ilk));
        chk("data_lock", idx, 64'(oDATA_LOCK), 64'(v.e_dlk));
        chk("inst_valid", idx, 64'(oINST_VALID), 64'(v.e_ivld));
        chk("data_valid", idx, 64'(oDATA_VALID), 64'(v.e_dvld));
        chk("mem_lock", idx, 64'(oMEM_LOCK), 64'(v.e_mlk));
        chk("outstanding", idx, 64'(oOUTSTANDING), 64'(v.e_out));
        if (v.e_mreq) begin
            chk("mem_rw", idx, 64'(oMEM_RW), 64'(v.e_win ? v.drw : 1'b0));
            chk("mem_addr", idx, 64'(oMEM_ADDR), 64'(v.e_win ? v.daddr : v.iaddr));
            chk("mem_order", idx, 64'(oMEM_ORDER), 64'(v.e_win ? v.dorder : ORDER_WORD));
            chk("mem_mask", idx, 64'(oMEM_MASK), 64'(v.e_win ? v.dmask : 4'hf));
            chk("mem_wdata", idx, 64'(oMEM_DATA), 64'(v.e_win ? v.ddata : 32'h0));
        end
        if (v.e_ivld || v.e_dvld) begin
            exp_line = init_line(v.e_raddr);
            if (v.e_abcd) exp_line[15:0] = 16'hABCD;
            chk(v.e_ivld ? "inst_data" : "data_data", idx,
                v.e_ivld ? oINST_DATA : oDATA_DATA, exp_line);
        end
        // memory model bookkeeping
        if (!v.rst_n) begin
            pend_q.delete();
        end else begin
            if (iMEM_VALID && !oMEM_LOCK && pend_q.size() > 0) void'(pend_q.pop_front());
            if (oMEM_REQ && !oMEM_RW) pend_q.push_back(oMEM_ADDR);
            if (oMEM_REQ && oMEM_RW) mem_write(oMEM_ADDR, oMEM_MASK, oMEM_DATA);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        inRESET = 1'b0;
        iINST_REQ = 1'b0; iINST_ADDR = '0; iINST_LOCK = 1'b0;
        iDATA_REQ = 1'b0; iDATA_RW = 1'b0; iDATA_ORDER = '0; iDATA_MASK = '0;
        iDATA_ADDR = '0; iDATA_DATA = '0; iDATA_LOCK = 1'b0;
        iMEM_LOCK = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = '0;

        // alternating grants, port 0 first after reset
        clr(); ri(32'h10); rd(1'b0, 32'h200); ex(1, 0, 0, 1, 0, 0);
        clr(); ri(32'h18); rd(1'b0, 32'h200); ex(1, 1, 1, 0, 0, 1);
        clr(); ri(32'h18); rd(1'b0, 32'h208); ex(1, 0, 0, 1, 0, 2);
        clr(); rd(1'b0, 32'h208);             ex(1, 1, 0, 0, 0, 3);
        clr(); resp(1'b0, 32'h10);  ex(0, 0, 0, 0, 0, 4);
        clr(); resp(1'b1, 32'h200); ex(0, 0, 0, 0, 0, 3);
        clr(); resp(1'b0, 32'h18);  ex(0, 0, 0, 0, 0, 2);
        clr(); resp(1'b1, 32'h208); ex(0, 0, 0, 0, 0, 1);
        clr(); ex(0, 0, 0, 0, 0, 0);

        // write consumes no tag; later read sees the written half
        clr(); ri(32'h0); wr_abcd(); ex(1, 0, 0, 1, 0, 0);
        clr(); wr_abcd();            ex(1, 1, 0, 0, 0, 1);
        clr();                       ex(0, 0, 0, 0, 0, 1);
        clr(); resp(1'b0, 32'h0);    ex(0, 0, 0, 0, 0, 1);
        clr(); rd(1'b0, 32'h100);    ex(1, 1, 0, 0, 0, 0);
        clr(); resp(1'b1, 32'h100); cur.e_abcd = 1'b1; ex(0, 0, 0, 0, 0, 1);
        clr();                       ex(0, 0, 0, 0, 0, 0);

        // memory lock blocks everything, port 0 wins after release
        for (int i = 0; i < 3; i++) begin
            clr(); ri(32'h40); rd(1'b0, 32'h300); cur.mlock = 1'b1; ex(0, 0, 1, 1, 0, 0);
        end
        clr(); ri(32'h40); rd(1'b0, 32'h300); ex(1, 0, 0, 1, 0, 0);
        clr(); rd(1'b0, 32'h300);             ex(1, 1, 0, 0, 0, 1);
        clr(); resp(1'b0, 32'h40);  ex(0, 0, 0, 0, 0, 2);
        clr(); resp(1'b1, 32'h300); ex(0, 0, 0, 0, 0, 1);
        clr(); ex(0, 0, 0, 0, 0, 0);

        // fill all 16 tags with port 0 locked, then drain through pointer wrap
        for (int i = 0; i < 16; i++) begin
            clr(); ri(32'h1000 + 32'(8*i)); cur.ilock = 1'b1; ex(1, 0, 0, 0, (i != 0), i);
        end
        clr(); ri(32'h1080); rd(1'b1, 32'h500); cur.ilock = 1'b1; ex(1, 1, 1, 0, 1, 16);
        clr(); ri(32'h1080); rd(1'b0, 32'h508); cur.ilock = 1'b1; cur.mvalid = 1'b1;
        ex(0, 0, 1, 1, 1, 16);
        clr(); ri(32'h1080); resp(1'b0, 32'h1000); ex(0, 0, 1, 0, 0, 16);
        clr(); ri(32'h1080); resp(1'b0, 32'h1008); ex(1, 0, 0, 0, 0, 15);
        for (int k = 0; k < 15; k++) begin
            clr(); resp(1'b0, 32'h1010 + 32'(8*k)); ex(0, 0, 0, 0, 0, 15 - k);
        end
        clr(); ex(0, 0, 0, 0, 0, 0);

        // head owned by a locked port 1 stalls both ports
        clr(); rd(1'b0, 32'h600); ex(1, 1, 0, 0, 0, 0);
        clr(); ri(32'h700);       ex(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            clr(); cur.mvalid = 1'b1; cur.dlock = 1'b1; ex(0, 0, 0, 0, 1, 2);
        end
        clr(); resp(1'b1, 32'h600); ex(0, 0, 0, 0, 0, 2);
        clr(); resp(1'b0, 32'h700); ex(0, 0, 0, 0, 0, 1);
        clr(); ex(0, 0, 0, 0, 0, 0);

        // reset with five reads in flight
        for (int i = 0; i < 5; i++) begin
            clr(); ri(32'h2000 + 32'(8*i)); ex(1, 0, 0, 0, 0, i);
        end
        clr(); cur.rst_n = 1'b0; ex(0, 0, 0, 0, 0, 5);
        clr(); ri(32'h3000); rd(1'b0, 32'h3100); ex(1, 0, 0, 1, 0, 0);
        clr(); rd(1'b0, 32'h3100);               ex(1, 1, 0, 0, 0, 1);
        clr(); resp(1'b0, 32'h3000); ex(0, 0, 0, 0, 0, 2);
        clr(); resp(1'b1, 32'h3100); ex(0, 0, 0, 0, 0, 1);
        clr(); ex(0, 0, 0, 0, 0, 0);

        // initial reset, checked by hand
        repeat (2) @(posedge iCLOCK);
        @(negedge iCLOCK);
        chk("reset_outstanding", -1, 64'(oOUTSTANDING), 64'd0);
        chk("reset_mem_req", -1, 64'(oMEM_REQ), 64'd0);
        chk("reset_mem_lock", -1, 64'(oMEM_LOCK), 64'd0);
        chk("reset_valids", -1, 64'({oINST_VALID, oDATA_VALID}), 64'd0);
        chk("reset_locks", -1, 64'({oINST_LOCK, oDATA_LOCK}), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_step(vecs[i], i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
